data_mem_resp: RTL and testbench
================================

DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter: ADDR_W, default 8, log2 of word depth; memory holds 2^ADDR_W 32-bit words.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req_valid  input  1  request present.
REQ-005 Port: req_ready  output  1  responder accepts a request this cycle.
REQ-006 Port: rw  input  1  1 = read (load), 0 = write (store).
REQ-007 Port: whb  input  2  access size: 10 word, 01 half, 00 byte, 11 treated as word.
REQ-008 Port: addr  input  32  byte address; word index addr[ADDR_W+1:2], upper bits ignored.
REQ-009 Port: wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 Port: resp_valid  output  1  response present.
REQ-011 Port: resp_ready  input  1  requester accepts response.
REQ-012 Port: rdata  output  32  load result, sign-extended; 0 for writes.
REQ-013 Port: resp_err  output  1  access fault flag, valid with resp_valid.

Function
REQ-014 FSM states IDLE, ACCESS, RESP; one request in flight at a time.
REQ-015 req_ready SHALL be 1 only in IDLE; handshake = req_valid && req_ready at rising edge captures rw, whb, addr, wdata and moves to ACCESS.
REQ-016 ACCESS lasts exactly one cycle: store committed to array at its closing edge, load data registered; next state RESP.
REQ-017 Load latency: resp_valid SHALL assert on the 2nd cycle after the accepting edge.
REQ-018 In RESP, resp_valid = 1 and rdata/resp_err SHALL stay stable until resp_valid && resp_ready; then IDLE at that edge.
REQ-019 Stores SHALL also produce a response (rdata = 0); minimum spacing between accepts is 3 cycles.
REQ-020 Little-endian: byte lane = addr[1:0], half lane = addr[1].
REQ-021 Byte store writes only lane addr[1:0] with wdata[7:0]; half store writes two lanes with wdata[15:0]; word store writes all four; untouched lanes SHALL keep their value.
REQ-022 LB returns selected byte sign-extended from bit 7; LH returns selected half sign-extended from bit 15; LW returns full word.
REQ-023 req_valid deasserted in IDLE SHALL cause no state change and no array access.
REQ-024 resp_ready high outside RESP SHALL be ignored.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, resp_valid = 0, rdata = 0, resp_err = 0, req_ready = 1 (once rst_n high).
REQ-026 Memory array SHALL NOT be reset; contents undefined at power-up and preserved across reset.
REQ-027 Reset asserted during ACCESS before its closing edge SHALL abort the store (no array write); a response in RESP is discarded.

Configuration
REQ-028 Macro DMEM_MISALIGN_CHK_EN defined: half with addr[0] = 1 or word with addr[1:0] != 00 is a fault: no array write, rdata = 0, resp_err = 1 in RESP, same latency.
REQ-029 Macro not defined: resp_err tied 0; half ignores addr[0], word ignores addr[1:0] (forced alignment).

Verification
REQ-030 SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 -> rdata 0xDEADBEEF, resp_err 0, resp_valid 2 cycles after accept.
REQ-031 After REQ-030, SB addr 0x13 wdata 0x00000080 -> LB 0x13 returns 0xFFFFFF80; LW 0x10 returns 0x80ADBEEF.
REQ-032 SH addr 0x16 wdata 0xFFFF1234 -> LH 0x16 returns 0x00001234; LH 0x14 returns previous low half unchanged.
REQ-033 LW with resp_ready held 0 for 3 cycles -> resp_valid, rdata stable, req_ready 0 throughout; IDLE one edge after resp_ready = 1.
REQ-034 LW addr 0x11: with DMEM_MISALIGN_CHK_EN -> resp_err 1, rdata 0; SW addr 0x12 leaves word 0x10 unchanged; without macro -> LW 0x11 returns word at 0x10.
REQ-035 rst_n pulsed low during ACCESS of SW 0x20 wdata 0x12345678 -> outputs 0 immediately; later LW 0x20 returns the pre-store value.

Source files
------------

// File: rtl/data_mem_resp.sv
// Request/response data memory: one access in flight, byte/half/word loads (sign-extended) and stores.
// Define DMEM_MISALIGN_CHK_EN to fault misaligned half/word accesses instead of forcing alignment.
module data_mem_resp #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        rw,
  input  logic [1:0]  whb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state, state_nxt;

  logic [31:0]       mem [2**ADDR_W];
  logic              rw_q;
  logic [1:0]        whb_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              accept;
  logic              resp_done;
  logic              fault;
  logic              do_write;
  logic [3:0]        be;
  logic [31:0]       wword;
  logic [31:0]       rword;
  logic [31:0]       lval;
  logic [7:0]        rbyte;
  logic [15:0]       rhalf;
  logic [ADDR_W-1:0] idx;
  logic              unused_addr;

  // Address bits above the array depth are don't-care.
  assign unused_addr = ^addr[31:ADDR_W+2];
  assign idx         = addr_q[ADDR_W+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    resp_done  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: state_nxt = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          resp_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef DMEM_MISALIGN_CHK_EN
  always_comb begin
    fault = 1'b0;
    case (whb_q)
      2'b01:        fault = addr_q[0];
      2'b10, 2'b11: fault = |addr_q[1:0];
      default:      fault = 1'b0;
    endcase
  end
`else
  assign fault = 1'b0;
`endif

  // Replicate store data across lanes so the byte enables alone pick the target lanes.
  always_comb begin
    be    = 4'b0000;
    wword = wdata_q;
    case (whb_q)
      2'b00: begin
        be    = 4'b0001 << addr_q[1:0];
        wword = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata_q[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  // Gated by state, so an async reset during ACCESS suppresses the write at the closing edge.
  assign do_write = (state == ACCESS) && !rw_q && !fault;

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  assign rword = mem[idx];

  always_comb begin
    rhalf = addr_q[1] ? rword[31:16] : rword[15:0];
    case (addr_q[1:0])
      2'b00:   rbyte = rword[7:0];
      2'b01:   rbyte = rword[15:8];
      2'b10:   rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
    case (whb_q)
      2'b00:   lval = {{24{rbyte[7]}}, rbyte};
      2'b01:   lval = {{16{rhalf[15]}}, rhalf};
      default: lval = rword;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_q    <= 1'b1;
      whb_q   <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        rw_q    <= rw;
        whb_q   <= whb;
        addr_q  <= addr[ADDR_W+1:0];
        wdata_q <= wdata;
      end
      if (state == ACCESS) begin
        rdata_q <= (rw_q && !fault) ? lval : 32'h0;
        err_q   <= fault;
      end else if (resp_done) begin
        rdata_q <= 32'h0;
        err_q   <= 1'b0;
      end
    end
  end

  assign rdata    = rdata_q;
  assign resp_err = err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Scoreboard bench for data_mem_resp: expectations queued at request time, checked at response.
// Misalignment expectations follow DMEM_MISALIGN_CHK_EN.
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        rw = 1'b0;
  logic [1:0]  whb = 2'b00;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] rdata;
  logic        resp_err;

  int          total = 0;
  int          bad = 0;
  logic [32:0] expq[$];

  data_mem_resp dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .rw(rw), .whb(whb), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .rdata(rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction; stall > 0 holds resp_ready low for that many cycles in RESP.
  task automatic applyStimulus(input string tag, input logic r, input logic [1:0] w,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] expData, input logic expErr, input int stall);
    int          cyc;
    logic [32:0] e;
    logic [31:0] held;
    @(negedge clk);
    req_valid  = 1'b1;
    rw         = r;
    whb        = w;
    addr       = a;
    wdata      = d;
    resp_ready = (stall == 0);
    expq.push_back({expErr, expData});
    cyc = 0;
    while (!req_ready && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    if (!req_ready) begin
      checkOutput({tag, "/accept_timeout"}, 32'd0, 32'd1);
      req_valid = 1'b0;
      void'(expq.pop_front());
      resp_ready = 1'b1;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rw        = 1'($urandom);
    whb       = 2'($urandom);
    addr      = $urandom;
    wdata     = $urandom;
    cyc = 1;
    while (!resp_valid && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!resp_valid) begin
      checkOutput({tag, "/resp_timeout"}, 32'd0, 32'd1);
      void'(expq.pop_front());
      resp_ready = 1'b1;
      return;
    end
    checkOutput({tag, "/latency"}, 32'(cyc), 32'd2);
    e = expq.pop_front();
    checkOutput({tag, "/rdata"}, rdata, e[31:0]);
    checkOutput({tag, "/err"}, {31'b0, resp_err}, {31'b0, e[32]});
    if (stall > 0) begin
      held = rdata;
      repeat (stall) begin
        @(posedge clk);
        #1;
        checkOutput({tag, "/hold_valid"}, {31'b0, resp_valid}, 32'd1);
        checkOutput({tag, "/hold_rdata"}, rdata, held);
        checkOutput({tag, "/hold_req_ready"}, {31'b0, req_ready}, 32'd0);
      end
      resp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    checkOutput({tag, "/idle_ready"}, {31'b0, req_ready}, 32'd1);
    checkOutput({tag, "/idle_valid"}, {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]  b[4];
    logic [31:0] rnd;
    logic [31:0] w10;

    #1;
    checkOutput("reset/valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("reset/rdata", rdata, 32'd0);
    checkOutput("reset/err", {31'b0, resp_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset/req_ready", {31'b0, req_ready}, 32'd1);

    // Idle bus with junk on the request fields must not start anything.
    repeat (4) begin
      @(negedge clk);
      rw = 1'($urandom);
      addr = $urandom;
      @(posedge clk);
      #1;
      checkOutput("idle/valid", {31'b0, resp_valid}, 32'd0);
      checkOutput("idle/req_ready", {31'b0, req_ready}, 32'd1);
    end

    applyStimulus("sw10", 1'b0, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    applyStimulus("lw10", 1'b1, 2'b10, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    applyStimulus("sb13", 1'b0, 2'b00, 32'h13, 32'h00000080, 32'h0, 1'b0, 0);
    applyStimulus("lb13", 1'b1, 2'b00, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 0);
    applyStimulus("lw10b", 1'b1, 2'b10, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, 0);
    applyStimulus("lw10_whb11", 1'b1, 2'b11, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, 0);
    applyStimulus("lb11", 1'b1, 2'b00, 32'h11, 32'h0, 32'hFFFFFFBE, 1'b0, 0);

    applyStimulus("sw14", 1'b0, 2'b10, 32'h14, 32'hA5A55A5A, 32'h0, 1'b0, 0);
    applyStimulus("sh16", 1'b0, 2'b01, 32'h16, 32'hFFFF1234, 32'h0, 1'b0, 0);
    applyStimulus("lh16", 1'b1, 2'b01, 32'h16, 32'h0, 32'h00001234, 1'b0, 0);
    applyStimulus("lh14", 1'b1, 2'b01, 32'h14, 32'h0, 32'h00005A5A, 1'b0, 0);
    applyStimulus("sh14", 1'b0, 2'b01, 32'h14, 32'h00008001, 32'h0, 1'b0, 0);
    applyStimulus("lh14neg", 1'b1, 2'b01, 32'h14, 32'h0, 32'hFFFF8001, 1'b0, 0);
    applyStimulus("lw14", 1'b1, 2'b10, 32'h14, 32'h0, 32'h12348001, 1'b0, 0);
    applyStimulus("lb15", 1'b1, 2'b00, 32'h15, 32'h0, 32'hFFFFFF80, 1'b0, 0);

    applyStimulus("lw10_stall", 1'b1, 2'b10, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, 3);

    // Reset during ACCESS of a store must leave the old word in place.
    applyStimulus("sw20", 1'b0, 2'b10, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, 0);
    @(negedge clk);
    req_valid = 1'b1; rw = 1'b0; whb = 2'b10; addr = 32'h20; wdata = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("rst_access/in_access", {31'b0, req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_access/valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rst_access/rdata", rdata, 32'd0);
    checkOutput("rst_access/err", {31'b0, resp_err}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_access/req_ready", {31'b0, req_ready}, 32'd1);
    applyStimulus("lw20_after_rst", 1'b1, 2'b10, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 0);

    // Reset while a load response is pending drops it immediately.
    @(negedge clk);
    req_valid = 1'b1; rw = 1'b1; whb = 2'b10; addr = 32'h20; resp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_resp/pending_rdata", rdata, 32'hCAFEF00D);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_resp/valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rst_resp/rdata", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_resp/stays_idle", {31'b0, resp_valid}, 32'd0);

    w10 = 32'h80ADBEEF;
`ifdef DMEM_MISALIGN_CHK_EN
    applyStimulus("lw11", 1'b1, 2'b10, 32'h11, 32'h0, 32'h0, 1'b1, 0);
    applyStimulus("lh11", 1'b1, 2'b01, 32'h11, 32'h0, 32'h0, 1'b1, 0);
    applyStimulus("sw12", 1'b0, 2'b10, 32'h12, 32'h11111111, 32'h0, 1'b1, 0);
    applyStimulus("lw10_after_sw12", 1'b1, 2'b10, 32'h10, 32'h0, w10, 1'b0, 0);
`else
    applyStimulus("lw11", 1'b1, 2'b10, 32'h11, 32'h0, w10, 1'b0, 0);
    applyStimulus("lh11", 1'b1, 2'b01, 32'h11, 32'h0, {{16{w10[15]}}, w10[15:0]}, 1'b0, 0);
    applyStimulus("sw12", 1'b0, 2'b10, 32'h12, 32'h11111111, 32'h0, 1'b0, 0);
    applyStimulus("lw10_after_sw12", 1'b1, 2'b10, 32'h10, 32'h0, 32'h11111111, 1'b0, 0);
`endif

    // Byte stores with random upper wdata bits build a word lane by lane.
    applyStimulus("sw40", 1'b0, 2'b10, 32'h40, 32'h0, 32'h0, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      rnd  = $urandom;
      b[i] = rnd[7:0];
      applyStimulus($sformatf("sb4%0d", i), 1'b0, 2'b00, 32'h40 + 32'(i), rnd, 32'h0, 1'b0, 0);
    end
    applyStimulus("lw40", 1'b1, 2'b10, 32'h40, 32'h0, {b[3], b[2], b[1], b[0]}, 1'b0, 0);
    applyStimulus("lb42", 1'b1, 2'b00, 32'h42, 32'h0, {{24{b[2][7]}}, b[2]}, 1'b0, 0);
    applyStimulus("lh42", 1'b1, 2'b01, 32'h42, 32'h0, {{16{b[3][7]}}, b[3], b[2]}, 1'b0, 0);

    checkOutput("scoreboard/empty", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
